frame_pixel_collector: RTL and testbench

//  Parametrised collector that assembles a raster-order pixel stream from the image memory reader into one flat frame word for the text-extraction core.

---
 rtl/frame_pixel_collector.sv | 147 ++++++++++++++
 tb/tb_frame_pixel_collector.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pixel_collector.sv
// -----------------------------------------------------------------------------
// frame_pixel_collector
//
// Purpose:
//   Assembles a raster-order pixel stream into one flat frame word. Pixel 0
//   lands in the most significant slot of frame_data. When the last pixel of
//   a frame is accepted, the frame is held (frame_valid=1, in_ready=0) until
//   the consumer acknowledges it with frame_ack. A pixel marked with in_sof
//   always restarts the frame at slot 0. If a partial frame was in progress,
//   frame_abort pulses for one cycle.
//
// Parameters:
//   PIXEL_WIDTH  bits per pixel
//   IMG_WIDTH    pixels per row
//   IMG_HEIGHT   rows per frame
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   in_valid     in_data / in_sof are valid
//   in_ready     collector accepts a pixel this cycle (registered)
//   in_data      pixel value
//   in_sof       pixel is the first pixel of a frame
//   frame_valid  frame_data holds a complete frame
//   frame_ack    consumer has taken the frame (only honoured while full)
//   frame_data   assembled frame, pixel 0 in the MSBs
//   pixel_count  number of pixels stored in the current frame
//   frame_abort  one-cycle pulse when in_sof discards a partial frame
//   frame_sum    modulo-2^16 pixel sum of the frame (FRAME_CHECKSUM_EN only)
//
// Build option:
//   FRAME_CHECKSUM_EN  when defined, adds the frame_sum port and its adder.
// -----------------------------------------------------------------------------
module frame_pixel_collector #(
  parameter  int PIXEL_WIDTH = 8,
  parameter  int IMG_WIDTH   = 16,
  parameter  int IMG_HEIGHT  = 16,
  localparam int NPIX        = IMG_WIDTH * IMG_HEIGHT,
  localparam int CNT_W       = $clog2(NPIX + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PIXEL_WIDTH-1:0]      in_data,
  input  logic                        in_sof,
  output logic                        frame_valid,
  input  logic                        frame_ack,
  output logic [PIXEL_WIDTH*NPIX-1:0] frame_data,
  output logic [CNT_W-1:0]            pixel_count,
  output logic                        frame_abort
`ifdef FRAME_CHECKSUM_EN
  ,
  output logic [15:0]                 frame_sum
`endif
);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t           state;
  logic             accept;
  logic [CNT_W-1:0] slot;
  logic [CNT_W-1:0] next_count;
  logic             frame_done;

  // in_ready is high only in COLLECT, so an accept can only occur there.
  assign accept = in_valid & in_ready;

  // A start-of-frame pixel always goes to slot 0, wherever the frame was.
  // next_count is the pixel count after this pixel is stored.
  always_comb begin
    slot       = in_sof ? '0 : pixel_count;
    next_count = slot + CNT_W'(1);
    frame_done = (next_count == CNT_W'(NPIX));
  end

  // NOTE: every register below is updated with non-blocking assignments.
  // Each assignment therefore reads pre-edge values (slot, pixel_count),
  // whatever order the statements appear in.
  // NOTE: frame_data is a bank of flops, not a RAM, so it has a defined
  // reset value of zero. It is never cleared after reset. Each new frame
  // overwrites the slots one by one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= COLLECT;
      in_ready    <= 1'b1;
      frame_valid <= 1'b0;
      frame_data  <= '0;
      pixel_count <= '0;
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            for (int k = 0; k < NPIX; k++) begin
              if (slot == CNT_W'(k)) begin
                frame_data[PIXEL_WIDTH*(NPIX-k)-1 -: PIXEL_WIDTH] <= in_data;
              end
            end
            pixel_count <= next_count;
            // Restarting with pixels already stored means a partial frame is lost.
            frame_abort <= in_sof && (pixel_count != '0);
            if (frame_done) begin
              state       <= FULL;
              frame_valid <= 1'b1;
              in_ready    <= 1'b0;
            end
          end
        end
        FULL: begin
          if (frame_ack) begin
            state       <= COLLECT;
            frame_valid <= 1'b0;
            in_ready    <= 1'b1;
            pixel_count <= '0;
          end
        end
        default: begin
          state       <= COLLECT;
          frame_valid <= 1'b0;
          in_ready    <= 1'b1;
          pixel_count <= '0;
        end
      endcase
    end
  end

`ifdef FRAME_CHECKSUM_EN
  // Running sum of the frame being collected. It restarts whenever slot 0 is
  // written: the first pixel of a new frame, or an in_sof restart. The sum
  // therefore stays valid while the frame is held in FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_sum <= 16'd0;
    end else if (accept) begin
      frame_sum <= ((slot == '0) ? 16'd0 : frame_sum) + 16'(in_data);
    end
  end
`else
  // Without FRAME_CHECKSUM_EN the checksum port and its adder do not exist.
`endif

endmodule

// File: tb/tb_frame_pixel_collector.sv
// -----------------------------------------------------------------------------
// tb_frame_pixel_collector
//
// Self-checking bench for frame_pixel_collector with PIXEL_WIDTH=8 and a
// 2x2 image (4 pixels per frame). A reference model tracks the current frame
// as a queue of accepted pixels plus the slot contents. It is compared
// against every DUT output after every clock edge. The directed scenarios
// add explicit checks against known constant values.
// -----------------------------------------------------------------------------
module tb_frame_pixel_collector;

  localparam int PW    = 8;
  localparam int IW    = 2;
  localparam int IH    = 2;
  localparam int NPIX  = IW * IH;
  localparam int CNT_W = $clog2(NPIX + 1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [PW-1:0]        in_data;
  logic                 in_sof;
  logic                 frame_valid;
  logic                 frame_ack;
  logic [PW*NPIX-1:0]   frame_data;
  logic [CNT_W-1:0]     pixel_count;
  logic                 frame_abort;
`ifdef FRAME_CHECKSUM_EN
  logic [15:0]          frame_sum;
`endif

  frame_pixel_collector #(
    .PIXEL_WIDTH (PW),
    .IMG_WIDTH   (IW),
    .IMG_HEIGHT  (IH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_sof      (in_sof),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .frame_data  (frame_data),
    .pixel_count (pixel_count),
    .frame_abort (frame_abort)
`ifdef FRAME_CHECKSUM_EN
    ,
    .frame_sum   (frame_sum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pixels of the frame in progress, the slot contents,
  // whether a complete frame is being held, and the expected abort pulse.
  logic [PW-1:0]      cur[$];
  logic [PW-1:0]      mem[NPIX];
  bit                 m_full;
  bit                 m_abort;
  logic [15:0]        m_sum;

  // Frames seen on the DUT (captured on the rising edge of frame_valid).
  logic [PW*NPIX-1:0] rx_frames[$];
  logic               fv_prev;
  int                 abort_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW*NPIX-1:0] model_frame();
    logic [PW*NPIX-1:0] r;
    r = '0;
    for (int k = 0; k < NPIX; k++) r[PW*(NPIX-k)-1 -: PW] = mem[k];
    return r;
  endfunction

  function automatic logic [15:0] queue_sum();
    int s;
    s = 0;
    foreach (cur[i]) s += int'(cur[i]);
    return 16'(s);
  endfunction

  task automatic model_reset();
    cur.delete();
    for (int k = 0; k < NPIX; k++) mem[k] = '0;
    m_full  = 1'b0;
    m_abort = 1'b0;
    m_sum   = 16'd0;
  endtask

  task automatic compare_all();
    check("in_ready",    in_ready,    !m_full);
    check("frame_valid", frame_valid, m_full);
    check("pixel_count", pixel_count, cur.size());
    check("frame_data",  frame_data,  model_frame());
    check("frame_abort", frame_abort, m_abort);
`ifdef FRAME_CHECKSUM_EN
    check("frame_sum",   frame_sum,   m_sum);
`endif
  endtask

  // Advance the model using the inputs currently driven, clock the DUT once,
  // then compare outputs 1 ns after the edge.
  task automatic cycle();
    m_abort = 1'b0;
    if (m_full) begin
      if (frame_ack) begin
        m_full = 1'b0;
        cur.delete();
      end
    end else if (in_valid) begin
      if (in_sof) begin
        if (cur.size() != 0) m_abort = 1'b1;
        cur.delete();
      end
      cur.push_back(in_data);
      mem[cur.size()-1] = in_data;
      m_sum = queue_sum();
      if (cur.size() == NPIX) m_full = 1'b1;
    end
    @(posedge clk);
    #1;
    compare_all();
    if (frame_abort) abort_seen++;
    if (frame_valid && !fv_prev) rx_frames.push_back(frame_data);
    fv_prev = frame_valid;
  endtask

  task automatic send(input logic [PW-1:0] d, input bit sof);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    cycle();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    fv_prev = 1'b0;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int nacc;
    int budget;
    logic [PW-1:0] sent[$];
    logic [PW*NPIX-1:0] exp_f;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sof    = 1'b0;
    frame_ack = 1'b0;
    abort_seen = 0;
    fv_prev   = 1'b0;

    // 1: reset values, then one frame.
    do_reset();
    check("rst_in_ready",    in_ready,    1'b1);
    check("rst_frame_valid", frame_valid, 1'b0);
    check("rst_frame_data",  frame_data,  32'h0);
    check("rst_pixel_count", pixel_count, 3'd0);
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    check("t1_frame_valid", frame_valid, 1'b1);
    check("t1_frame_data",  frame_data,  32'h11223344);
    check("t1_in_ready",    in_ready,    1'b0);

    // 2: hold without ack while offering pixels; then acknowledge.
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (5) cycle();
    in_valid = 1'b0;
    check("t2_frame_stable", frame_data,  32'h11223344);
    check("t2_pixel_count",  pixel_count, 3'd4);
    frame_ack = 1'b1;
    cycle();
    frame_ack = 1'b0;
    check("t2_ack_ready", in_ready,    1'b1);
    check("t2_ack_count", pixel_count, 3'd0);

    // 3: in_sof restart in the middle of a frame.
    abort_seen = 0;
    send(8'hAA, 1'b1);
    send(8'hBB, 1'b0);
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    check("t3_abort_pulses", abort_seen, 1);
    check("t3_frame_data",   frame_data, 32'h01020304);
    frame_ack = 1'b1;
    cycle();

    // 4: random in_valid over three frames with frame_ack tied high.
    rx_frames.delete();
    sent.delete();
    nacc   = 0;
    budget = 0;
    while (nacc < 3 * NPIX && budget < 400) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      in_sof   = (nacc % NPIX) == 0;
      if (in_valid && !m_full) begin
        sent.push_back(in_data);
        nacc++;
      end
      cycle();
      budget++;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (3) cycle();
    check("t4_accepted", nacc, 3 * NPIX);
    check("t4_frames",   rx_frames.size(), 3);
    for (int f = 0; f < 3; f++) begin
      exp_f = '0;
      for (int k = 0; k < NPIX; k++)
        if (f * NPIX + k < sent.size()) exp_f[PW*(NPIX-k)-1 -: PW] = sent[f*NPIX+k];
      if (f < rx_frames.size()) check($sformatf("t4_frame%0d", f), rx_frames[f], exp_f);
      else                      check($sformatf("t4_frame%0d", f), 0, exp_f);
    end
    frame_ack = 1'b0;

    // 5: asynchronous reset after three pixels, then a clean frame.
    send(8'h31, 1'b1);
    send(8'h32, 1'b0);
    send(8'h33, 1'b0);
    #2;
    do_reset();
    check("t5_rst_count", pixel_count, 3'd0);
    check("t5_rst_ready", in_ready,    1'b1);
    check("t5_rst_data",  frame_data,  32'h0);
    send(8'hC1, 1'b1);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    send(8'hC4, 1'b0);
    check("t5_frame_data",  frame_data,  32'hC1C2C3C4);
    check("t5_frame_valid", frame_valid, 1'b1);
    frame_ack = 1'b1;
    cycle();
    frame_ack = 1'b0;

    // 6: all-ones frame, which exercises the checksum when it is built in.
    send(8'hFF, 1'b1);
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    send(8'hFF, 1'b0);
    check("t6_frame_data", frame_data, 32'hFFFFFFFF);
`ifdef FRAME_CHECKSUM_EN
    check("t6_frame_sum", frame_sum, 16'h03FC);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
